// File: rtl/mem_responder_if.sv
// MAR/MDR memory bus between the CPU datapath (master) and the memory responder (slave).
// Port names follow the datapath's existing signal names.
interface mem_responder_if #(
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0] BusMuxOut;
  logic              MARin;
  logic              Read;
  logic              Write;
  logic [DATA_W-1:0] MDRdata;
  logic [DATA_W-1:0] Mdatain;
  logic              MemReady;
  logic              MemBusy;
  logic              AddrErr;

  modport master (
    output BusMuxOut, MARin, Read, Write, MDRdata,
    input  Mdatain, MemReady, MemBusy, AddrErr
  );

  modport slave (
    input  BusMuxOut, MARin, Read, Write, MDRdata,
    output Mdatain, MemReady, MemBusy, AddrErr
  );
endinterface

// File: rtl/mem_responder.sv
// Memory-side responder for the datapath's MAR/MDR interface: edge-detected Read/Write
// requests, fixed-latency reads, single-cycle write acknowledge, out-of-range flagging.
module mem_responder #(
  parameter int    ADDR_W       = 9,
  parameter int    DATA_W       = 32,
  parameter int    DEPTH        = 512,
  parameter int    READ_LATENCY = 2,
  parameter string INIT_FILE    = ""
) (
  input  logic          Clock,
  input  logic          Resetn,
  mem_responder_if.slave bus
);
  localparam int              IDX_W     = $clog2(DEPTH);
  localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, RWAIT, WRESP} state_t;

  state_t            state;
  logic [ADDR_W-1:0] mar;
  logic [IDX_W-1:0]  raddr;
  logic              rd_ok;
  logic              wr_err;
  logic [3:0]        cnt;
  logic              read_q;
  logic              write_q;
  logic [DATA_W-1:0] mem [DEPTH];

  logic in_range;
  logic new_rd;
  logic new_wr;

  assign in_range = ({1'b0, mar} < DEPTH_LIM);
  assign new_rd   = bus.Read  & ~read_q;
  assign new_wr   = bus.Write & ~write_q;

  // NOTE: storage has no reset branch so it maps onto RAM; contents survive Resetn.
  always_ff @(posedge Clock) begin
    if (state == IDLE && new_wr && in_range)
      mem[mar[IDX_W-1:0]] <= bus.MDRdata;
  end

  // NOTE: all state below uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state        <= IDLE;
      mar          <= '0;
      raddr        <= '0;
      rd_ok        <= 1'b0;
      wr_err       <= 1'b0;
      cnt          <= '0;
      read_q       <= 1'b0;
      write_q      <= 1'b0;
      bus.Mdatain  <= '0;
      bus.MemReady <= 1'b0;
      bus.MemBusy  <= 1'b0;
      bus.AddrErr  <= 1'b0;
    end else begin
      read_q       <= bus.Read;
      write_q      <= bus.Write;
      bus.MemReady <= 1'b0;
      bus.AddrErr  <= 1'b0;
      if (bus.MARin) mar <= bus.BusMuxOut[ADDR_W-1:0];

      case (state)
        IDLE: begin
          // A write beats a simultaneous read; the dropped read is reported as an error.
          if (new_wr) begin
            wr_err      <= ~in_range | new_rd;
            bus.MemBusy <= 1'b1;
            state       <= WRESP;
          end else if (new_rd) begin
            raddr       <= mar[IDX_W-1:0];
            rd_ok       <= in_range;
            cnt         <= 4'(READ_LATENCY - 1);
            bus.MemBusy <= 1'b1;
            state       <= RWAIT;
          end
        end
        RWAIT: begin
          if (cnt == '0) begin
            bus.Mdatain  <= rd_ok ? mem[raddr] : '0;
            bus.MemReady <= 1'b1;
            bus.AddrErr  <= ~rd_ok;
            bus.MemBusy  <= 1'b0;
            state        <= IDLE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        WRESP: begin
          bus.MemReady <= 1'b1;
          bus.AddrErr  <= wr_err;
          bus.MemBusy  <= 1'b0;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: expected completions are queued at request time and
// compared on every MemReady pulse; latency, busy and reset behaviour are checked inline.
module tb_mem_responder;
  localparam int ADDR_W = 9;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 256;
  localparam int LAT    = 2;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              err;
  } exp_t;

  logic Clock;
  logic Resetn;
  mem_responder_if #(.DATA_W(DATA_W)) bus ();

  mem_responder #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .READ_LATENCY(LAT), .INIT_FILE("")
  ) dut (
    .Clock (Clock),
    .Resetn(Resetn),
    .bus   (bus)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int                vectors = 0;
  int                errors  = 0;
  int                ready_cnt = 0;
  exp_t              sb[$];
  logic [DATA_W-1:0] model [DEPTH];
  logic [ADDR_W-1:0] mar_m;
  logic [DATA_W-1:0] last_rd;

  task automatic check(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Completion monitor: every MemReady pulse must match the oldest queued expectation.
  always @(negedge Clock) begin
    if (bus.MemReady === 1'b1) begin
      ready_cnt++;
      if (sb.size() == 0) begin
        check("unexpected_ready", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("rd_data", bus.Mdatain, e.data);
        check("addr_err", 32'(bus.AddrErr), 32'(e.err));
      end
    end
  end

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic load_mar(input logic [ADDR_W-1:0] a);
    bus.BusMuxOut = 32'(a);
    bus.MARin     = 1'b1;
    step();
    bus.MARin     = 1'b0;
    mar_m         = a;
  endtask

  task automatic wait_ready(input int lat, input string tag);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (bus.MemReady !== 1'b1 && n < 20);
    check(tag, 32'(n), 32'(lat));
  endtask

  function automatic exp_t read_exp();
    exp_t e;
    e.err  = (32'(mar_m) >= DEPTH);
    e.data = e.err ? '0 : model[mar_m[7:0]];
    return e;
  endfunction

  task automatic do_read(input string tag);
    exp_t e;
    e = read_exp();
    sb.push_back(e);
    last_rd  = e.data;
    bus.Read = 1'b1;
    step();
    bus.Read = 1'b0;
    check({tag, "_busy"}, 32'(bus.MemBusy), 32'd1);
    wait_ready(LAT, {tag, "_lat"});
    step();
  endtask

  task automatic do_write(input logic [DATA_W-1:0] d, input string tag);
    exp_t e;
    e.err  = (32'(mar_m) >= DEPTH);
    e.data = last_rd;
    if (!e.err) model[mar_m[7:0]] = d;
    sb.push_back(e);
    bus.MDRdata = d;
    bus.Write   = 1'b1;
    step();
    bus.Write   = 1'b0;
    check({tag, "_busy"}, 32'(bus.MemBusy), 32'd1);
    wait_ready(1, {tag, "_lat"});
    check({tag, "_mdatain_kept"}, bus.Mdatain, last_rd);
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running, expected done");
    $fatal(1, "timeout");
  end

  initial begin
    int n0;
    exp_t e;
    Resetn        = 1'b0;
    bus.BusMuxOut = '0;
    bus.MARin     = 1'b0;
    bus.Read      = 1'b0;
    bus.Write     = 1'b0;
    bus.MDRdata   = '0;
    mar_m         = '0;
    last_rd       = '0;
    repeat (3) step();
    check("rst_mdatain", bus.Mdatain, 32'd0);
    check("rst_ready", 32'(bus.MemReady), 32'd0);
    check("rst_busy", 32'(bus.MemBusy), 32'd0);
    check("rst_err", 32'(bus.AddrErr), 32'd0);
    Resetn = 1'b1;
    step();

    // Preload mem[5] and read it back with latency 2.
    load_mar(9'd5);
    do_write(32'h1848_C000, "wr5");
    do_read("rd5");

    // Write then read back; Mdatain must not move on the write.
    load_mar(9'h10);
    do_write(32'h14, "wr10");
    do_read("rd10");

    // Read held high for 4 edges issues a single request.
    load_mar(9'd5);
    e = read_exp();
    sb.push_back(e);
    last_rd  = e.data;
    n0       = ready_cnt;
    bus.Read = 1'b1;
    repeat (4) step();
    bus.Read = 1'b0;
    repeat (3) step();
    check("held_one_ready", 32'(ready_cnt - n0), 32'd1);

    // New read edge while busy is ignored, and a held Read is not re-issued afterwards.
    load_mar(9'h10);
    e = read_exp();
    sb.push_back(e);
    last_rd  = e.data;
    n0       = ready_cnt;
    bus.Read = 1'b1;
    step();
    bus.Read = 1'b0;
    step();
    bus.Read = 1'b1;
    repeat (5) step();
    check("busy_ignored", 32'(ready_cnt - n0), 32'd1);
    bus.Read = 1'b0;
    step();
    e = read_exp();
    sb.push_back(e);
    bus.Read = 1'b1;
    step();
    bus.Read = 1'b0;
    wait_ready(LAT, "reissue_lat");
    step();
    check("reissue_ready", 32'(ready_cnt - n0), 32'd2);

    // Simultaneous Read+Write: write wins, AddrErr flags the dropped read.
    load_mar(9'd7);
    e.data      = last_rd;
    e.err       = 1'b1;
    model[7]    = 32'h18;
    sb.push_back(e);
    n0          = ready_cnt;
    bus.MDRdata = 32'h18;
    bus.Read    = 1'b1;
    bus.Write   = 1'b1;
    step();
    bus.Read    = 1'b0;
    bus.Write   = 1'b0;
    wait_ready(1, "rw_lat");
    repeat (4) step();
    check("rw_one_ready", 32'(ready_cnt - n0), 32'd1);
    do_read("rd7");

    // Out-of-range accesses: read returns 0, write is discarded (no alias onto 0xFF).
    load_mar(9'hFF);
    do_write(32'hA5A5_0FF0, "wrFF");
    load_mar(9'h1FF);
    do_read("rd1FF");
    do_write(32'hDEAD_BEEF, "wr1FF");
    load_mar(9'hFF);
    do_read("rdFF");

    // Asynchronous reset in the middle of a read.
    load_mar(9'h20);
    do_write(32'h12, "wr20");
    do_read("rd20");
    load_mar(9'h10);
    bus.Read = 1'b1;
    step();
    bus.Read = 1'b0;
    #2;
    Resetn = 1'b0;
    #1;
    check("arst_mdatain", bus.Mdatain, 32'd0);
    check("arst_busy", 32'(bus.MemBusy), 32'd0);
    check("arst_ready", 32'(bus.MemReady), 32'd0);
    mar_m   = '0;
    last_rd = '0;
    n0      = ready_cnt;
    repeat (2) step();
    Resetn = 1'b1;
    repeat (5) step();
    check("arst_no_ready", 32'(ready_cnt - n0), 32'd0);
    check("arst_idle", 32'(bus.MemBusy), 32'd0);

    // Reset reloaded MAR with 0: a write/read at address 0 proves it.
    do_write(32'h0BAD_CAFE, "wr0");
    do_read("rd0");

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
